apu_aout_mc: RTL and testbench
==============================

APU_AOUT_MC -- requirements
Module: apu_aout_mc

Interface
REQ-001 Parameter CHANNELS, default 2: number of output channels, range 1..8.
REQ-002 Parameter SAMPLE_W, default 16: signed sample width per channel, range 8..24.
REQ-003 Parameter OSR_LOG2, default 4: log2 of ticks per consumed frame, range 0..6.
REQ-004 clk  in  1: sole clock.
REQ-005 rst_n  in  1: asynchronous active-low reset.
REQ-006 en  in  1: block enable; low holds all state cleared.
REQ-007 interval  in  8: tick period in quarter-cycles.
REQ-008 s_data  in  CHANNELS*SAMPLE_W: frame, channel 0 in LSBs, two's complement.
REQ-009 s_valid  in  1: s_data valid.
REQ-010 s_ready  out  1: frame consumed this cycle if s_valid.
REQ-011 underrun_clr  in  1: clears underrun.
REQ-012 underrun  out  1: sticky, slot passed with s_valid low.
REQ-013 tick  out  1: one-cycle strobe per upsample tick.
REQ-014 pwm  out  CHANNELS: one-bit modulator output per channel.

Function
REQ-015 The rate generator SHALL add 4 to a 9-bit phase accumulator every enabled cycle; when the result is >= I, it SHALL subtract I and pulse tick. I = max(interval, 4).
REQ-016 Average tick spacing SHALL equal I/4 cycles exactly; the gap between any two ticks SHALL be floor(I/4) or ceil(I/4) cycles.
REQ-017 An OSR_LOG2-bit tick counter SHALL advance on each tick; the cycle in which tick occurs with the counter at 0 is the frame slot.
REQ-018 s_ready SHALL be high exactly in the frame slot cycle, independent of s_valid; for OSR_LOG2=0 every tick is a slot.
REQ-019 On s_valid && s_ready the block SHALL latch s_data into per-channel hold registers, visible to the modulators the next cycle.
REQ-020 In a slot with s_valid low the block SHALL keep the hold registers unchanged and set underrun.
REQ-021 underrun SHALL clear on underrun_clr; a simultaneous new underrun SHALL win (flag stays set).
REQ-022 Each channel SHALL convert its held sample to offset binary (MSB inverted) and drive a first-order sigma-delta modulator every enabled cycle: {carry, acc} = acc + d, pwm = carry, acc SAMPLE_W bits.
REQ-023 Long-run pwm duty SHALL equal d / 2^SAMPLE_W; held sample 0 SHALL give exactly 50 % duty alternating 1,0.
REQ-024 en low SHALL, synchronously within one cycle, zero the phase accumulator, tick counter, hold registers and SDM accumulators, force s_ready, tick and pwm to 0, and preserve underrun.
REQ-025 After en rises, the first tick SHALL occur ceil(I/4) cycles later, and that tick SHALL be a frame slot.
REQ-026 Changing interval mid-operation SHALL take effect on the next accumulator compare, with no lost or double ticks beyond the new period.

Reset
REQ-027 On rst_n low all registers SHALL clear asynchronously: s_ready=0, tick=0, underrun=0, pwm=0, hold registers=0.
REQ-028 Reset deassertion mid-frame SHALL restart at REQ-025 behaviour once en is high.

Configuration
REQ-029 Macro APU_AOUT_MC_VOLUME_EN defined: port vol in CHANNELS*8 SHALL exist.
REQ-030 With that macro, each held sample SHALL be scaled as (sample * vol_ch) arithmetic-shifted right 8 before offset conversion; vol 0 SHALL mute (50 % duty) and vol 255 SHALL give 255/256 gain.
REQ-031 Macro absent: no vol port, and samples SHALL pass unscaled.

Structure
REQ-032 Package apu_pkg SHALL hold the parameter range limits, the minimum interval constant (4) and the quarter-cycle increment constant.
REQ-033 The per-channel modulator (REQ-022) SHALL be sub-module apu_aout_mc_sdm with a SAMPLE_W parameter, instantiated CHANNELS times via generate.

Verification
REQ-034 interval=125, OSR_LOG2=4, s_valid constant 1 -> 4 ticks per 125 cycles, gaps of 31/31/31/32, one s_ready per 500 cycles.
REQ-035 CHANNELS=2, frames {ch0=0x4000, ch1=0xC000} -> ch0 duty 75 %, ch1 duty 25 % over 65536 cycles, within ±1 count.
REQ-036 s_valid held low across a slot -> underrun=1, pwm statistics unchanged; underrun_clr pulsed in a later underrun slot -> underrun stays 1.
REQ-037 interval=0..3 -> tick every cycle; en dropped mid-frame -> pwm=0 next cycle; en restored -> first s_ready after ceil(I/4) cycles.
REQ-038 APU_AOUT_MC_VOLUME_EN, sample 0x7FFF, vol 128 -> effective sample 0x3FFF; vol 0 -> 1,0 alternation.
REQ-039 rst_n pulsed low asynchronously between clock edges mid-frame -> all outputs 0 immediately, underrun=0.

Source files
------------

// File: rtl/apu_pkg.sv
// Shared constants and helpers for the apu_aout_mc multichannel audio output block.
package apu_pkg;

  localparam int unsigned CHANNELS_MIN = 1;
  localparam int unsigned CHANNELS_MAX = 8;
  localparam int unsigned SAMPLE_W_MIN = 8;
  localparam int unsigned SAMPLE_W_MAX = 24;
  localparam int unsigned OSR_LOG2_MIN = 0;
  localparam int unsigned OSR_LOG2_MAX = 6;

  localparam int unsigned INTERVAL_W   = 8;
  localparam int unsigned PHASE_W      = 9;
  localparam int unsigned INTERVAL_MIN = 4;
  localparam int unsigned PHASE_INC    = 4;
  localparam int unsigned VOL_W        = 8;

  // Effective tick period in quarter-cycles; periods below one cycle saturate to one.
  function automatic logic [PHASE_W-1:0] eff_interval(input logic [INTERVAL_W-1:0] iv);
    if (iv < INTERVAL_W'(INTERVAL_MIN)) begin
      return PHASE_W'(INTERVAL_MIN);
    end
    return PHASE_W'(iv);
  endfunction

endpackage

// File: rtl/apu_aout_mc_sdm.sv
// First-order sigma-delta modulator for one channel; sample is two's complement,
// modulated as offset binary so that a zero sample yields a 1,0 square wave.
module apu_aout_mc_sdm #(
  parameter int unsigned SAMPLE_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [SAMPLE_W-1:0] sample,
  output logic                pwm
);

  logic [SAMPLE_W-1:0] acc_q;
  logic [SAMPLE_W-1:0] d_c;
  logic [SAMPLE_W:0]   sum_c;

  assign d_c   = {~sample[SAMPLE_W-1], sample[SAMPLE_W-2:0]};
  assign sum_c = {1'b0, acc_q} + {1'b0, d_c};

  // Carry out of the accumulator is the one-bit density output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      pwm   <= 1'b0;
    end else if (!en) begin
      acc_q <= '0;
      pwm   <= 1'b0;
    end else begin
      acc_q <= sum_c[SAMPLE_W-1:0];
      pwm   <= sum_c[SAMPLE_W];
    end
  end

endmodule

// File: rtl/apu_aout_mc.sv
// Multichannel audio output: fractional tick generator, frame slot/hold logic with
// sticky underrun, and one sigma-delta modulator per channel.
// Optional per-channel volume scaling is built when APU_AOUT_MC_VOLUME_EN is defined.
module apu_aout_mc
  import apu_pkg::*;
#(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned OSR_LOG2 = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [INTERVAL_W-1:0]        interval,
  input  logic [CHANNELS*SAMPLE_W-1:0] s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic                         underrun_clr,
`ifdef APU_AOUT_MC_VOLUME_EN
  input  logic [CHANNELS*VOL_W-1:0]    vol,
`endif
  output logic                         underrun,
  output logic                         tick,
  output logic [CHANNELS-1:0]          pwm
);

  localparam int unsigned CNT_W = (OSR_LOG2 > 0) ? OSR_LOG2 : 1;

  logic [PHASE_W-1:0]           phase_q;
  logic [PHASE_W-1:0]           ival_c;
  logic [PHASE_W-1:0]           phase_sum_c;
  logic [PHASE_W-1:0]           phase_next_c;
  logic                         tick_c;
  logic                         slot_c;
  logic [CNT_W-1:0]             cnt_q;
  logic [CHANNELS*SAMPLE_W-1:0] hold_q;

  // Phase accumulator compare; a lowered interval that leaves the residue out of
  // range restarts the phase instead of emitting a burst of catch-up ticks.
  always_comb begin
    ival_c       = eff_interval(interval);
    phase_sum_c  = phase_q + PHASE_W'(PHASE_INC);
    tick_c       = (phase_sum_c >= ival_c);
    phase_next_c = phase_sum_c;
    if (tick_c) begin
      phase_next_c = phase_sum_c - ival_c;
      if (phase_next_c >= ival_c) begin
        phase_next_c = '0;
      end
    end
    slot_c = tick_c && ((OSR_LOG2 == 0) || (cnt_q == '0));
  end

  // Rate generator and frame slot strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
      cnt_q   <= '0;
      tick    <= 1'b0;
      s_ready <= 1'b0;
    end else if (!en) begin
      phase_q <= '0;
      cnt_q   <= '0;
      tick    <= 1'b0;
      s_ready <= 1'b0;
    end else begin
      phase_q <= phase_next_c;
      tick    <= tick_c;
      s_ready <= slot_c;
      if (tick_c && (OSR_LOG2 != 0)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Frame capture and sticky underrun; a new underrun beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q   <= '0;
      underrun <= 1'b0;
    end else if (!en) begin
      hold_q   <= '0;
    end else begin
      if (s_ready && s_valid) begin
        hold_q <= s_data;
      end
      if (s_ready && !s_valid) begin
        underrun <= 1'b1;
      end else if (underrun_clr) begin
        underrun <= 1'b0;
      end
    end
  end

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    logic [SAMPLE_W-1:0] samp_c;
    logic [SAMPLE_W-1:0] scaled_c;

    assign samp_c = hold_q[ch*SAMPLE_W +: SAMPLE_W];

`ifdef APU_AOUT_MC_VOLUME_EN
    // Signed sample times unsigned volume, then arithmetic shift by 8.
    logic signed [SAMPLE_W+VOL_W:0] prod_c;
    assign prod_c   = (SAMPLE_W+VOL_W+1)'($signed(samp_c))
                    * (SAMPLE_W+VOL_W+1)'($signed({1'b0, vol[ch*VOL_W +: VOL_W]}));
    assign scaled_c = SAMPLE_W'(prod_c >>> VOL_W);
`else
    assign scaled_c = samp_c;
`endif

    apu_aout_mc_sdm #(
      .SAMPLE_W (SAMPLE_W)
    ) u_sdm (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .sample (scaled_c),
      .pwm    (pwm[ch])
    );
  end

endmodule

// File: tb/tb_apu_aout_mc.sv
// Bench for apu_aout_mc: cycle-level reference model with per-cycle comparison,
// plus directed checks of tick spacing, slot timing, duty, underrun and reset.
module tb_apu_aout_mc;

  localparam int unsigned CH  = 2;
  localparam int unsigned SW  = 16;
  localparam int unsigned OSR = 4;

  logic          clk          = 1'b0;
  logic          rst_n        = 1'b0;
  logic          en           = 1'b0;
  logic [7:0]    interval     = 8'd125;
  logic [CH*SW-1:0] s_data    = '0;
  logic          s_valid      = 1'b0;
  logic          s_ready;
  logic          underrun_clr = 1'b0;
  logic          underrun;
  logic          tick;
  logic [CH-1:0] pwm;
`ifdef APU_AOUT_MC_VOLUME_EN
  logic [CH*8-1:0] vol = {8'd128, 8'd255};
`endif

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  apu_aout_mc #(
    .CHANNELS (CH),
    .SAMPLE_W (SW),
    .OSR_LOG2 (OSR)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .interval     (interval),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .underrun_clr (underrun_clr),
`ifdef APU_AOUT_MC_VOLUME_EN
    .vol          (vol),
`endif
    .underrun     (underrun),
    .tick         (tick),
    .pwm          (pwm)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  // Reference model: quarter-cycle phase bookkeeping, frame counter, held samples,
  // and an integer density accumulator per channel.
  int            m_phase = 0;
  int            m_cnt   = 0;
  int            m_ival  = 4;
  int            m_d     = 0;
  int            m_hold[CH];
  int            m_acc[CH];
  logic          m_tick  = 1'b0;
  logic          m_ready = 1'b0;
  logic          m_unr   = 1'b0;
  logic [CH-1:0] m_pwm   = '0;
  logic signed [SW-1:0] m_smp;

  task automatic model_step();
    if (!rst_n || !en) begin
      if (!rst_n) m_unr = 1'b0;
      m_phase = 0;
      m_cnt   = 0;
      m_tick  = 1'b0;
      m_ready = 1'b0;
      m_pwm   = '0;
      for (int c = 0; c < CH; c++) begin
        m_hold[c] = 0;
        m_acc[c]  = 0;
      end
    end else begin
      for (int c = 0; c < CH; c++) begin
`ifdef APU_AOUT_MC_VOLUME_EN
        m_d = ((m_hold[c] * int'(vol[c*8 +: 8])) >>> 8) + 32768;
`else
        m_d = m_hold[c] + 32768;
`endif
        m_acc[c] = m_acc[c] + m_d;
        m_pwm[c] = (m_acc[c] >= 65536);
        m_acc[c] = m_acc[c] % 65536;
        if (m_ready && s_valid) begin
          m_smp     = s_data[c*SW +: SW];
          m_hold[c] = int'(m_smp);
        end
      end
      if (m_ready && !s_valid) m_unr = 1'b1;
      else if (underrun_clr)   m_unr = 1'b0;
      m_ival  = (interval < 8'd4) ? 4 : int'(interval);
      m_phase = m_phase + 4;
      if (m_phase >= m_ival) begin
        m_phase = m_phase - m_ival;
        m_tick  = 1'b1;
        m_ready = (m_cnt == 0);
        m_cnt   = (m_cnt + 1) % (1 << OSR);
      end else begin
        m_tick  = 1'b0;
        m_ready = 1'b0;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) model_step();

  always @(negedge clk) begin
    if (chk_en) begin
      chk("tick", tick, m_tick);
      chk("s_ready", s_ready, m_ready);
      chk("underrun", underrun, m_unr);
      chk("pwm", pwm, m_pwm);
    end
  end

  task automatic wait_tick(input int bound, output int n);
    n = -1;
    for (int k = 1; k <= bound; k++) begin
      @(negedge clk);
      if (tick) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic wait_slot(input int bound, output int n);
    n = -1;
    for (int k = 1; k <= bound; k++) begin
      @(negedge clk);
      if (s_ready) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    int   n;
    int   total;
    int   ones0;
    int   ones1;
    logic prev;

    repeat (3) @(negedge clk);
    chk("rst_tick", tick, 0);
    chk("rst_ready", s_ready, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_pwm", pwm, 0);
    rst_n   = 1'b1;
    chk_en  = 1'b1;
    s_data  = {16'hC000, 16'h4000};
    s_valid = 1'b1;

    // Tick spacing at interval 125 and frame period
    @(negedge clk);
    en = 1'b1;
    wait_tick(100, n);
    chk("first_tick_delay", n, 32);
    chk("first_tick_is_slot", s_ready, 1);
    total = 0;
    wait_tick(100, n); chk("gap1", n, 31); total += n;
    wait_tick(100, n); chk("gap2", n, 31); total += n;
    wait_tick(100, n); chk("gap3", n, 31); total += n;
    wait_tick(100, n); chk("gap4", n, 32); total += n;
    for (int k = 0; k < 20; k++) begin
      wait_tick(100, n);
      total += n;
      if (n < 0 || s_ready) break;
    end
    chk("frame_period", total, 500);

    // Duty of 0x4000 / 0xC000 over 65536 cycles
    ones0 = 0;
    ones1 = 0;
    repeat (65536) begin
      @(negedge clk);
      ones0 += int'(pwm[0]);
      ones1 += int'(pwm[1]);
    end
    chk_range("duty_ch0", ones0, 49151, 49153);
    chk_range("duty_ch1", ones1, 16383, 16385);

    // Underrun, then a clear that collides with a second underrun
    s_valid = 1'b0;
    wait_slot(1000, n);
    chk("slot_seen_a", int'(n > 0), 1);
    @(negedge clk);
    chk("underrun_set", underrun, 1);
    wait_slot(1000, n);
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    chk("underrun_beats_clr", underrun, 1);

    // Enable dropped mid-frame, restart with sub-cycle interval
    repeat (7) @(negedge clk);
    s_valid = 1'b1;
    en      = 1'b0;
    @(negedge clk);
    chk("en_low_pwm", pwm, 0);
    chk("en_low_tick", tick, 0);
    chk("en_low_ready", s_ready, 0);
    chk("en_low_keeps_underrun", underrun, 1);
    interval = 8'd3;
    en       = 1'b1;
    wait_tick(10, n);
    chk("fast_first_tick", n, 1);
    chk("fast_first_slot", s_ready, 1);
    repeat (4) begin
      @(negedge clk);
      chk("fast_tick_every_cycle", tick, 1);
    end
    en = 1'b0;
    @(negedge clk);
    interval = 8'd10;
    en       = 1'b1;
    wait_tick(20, n);
    chk("i10_first_tick", n, 3);
    chk("i10_first_slot", s_ready, 1);
    @(negedge clk);
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    chk("underrun_cleared", underrun, 0);

    // Interval raised mid-operation, directed frames
    interval = 8'd20;
    s_data   = {16'h7FFF, 16'h0000};
    wait_slot(1000, n);
    chk("slot_seen_b", int'(n > 0), 1);
    repeat (3) @(negedge clk);
    prev = pwm[0];
    repeat (8) begin
      @(negedge clk);
      chk("zero_alternates", pwm[0], !prev);
      prev = pwm[0];
    end
    s_data = {16'h8000, 16'h1234};
    wait_slot(1000, n);
    repeat (100) @(negedge clk);

    // Async reset between edges while underrun is set
    s_valid = 1'b0;
    wait_slot(1000, n);
    @(negedge clk);
    chk("underrun_set_again", underrun, 1);
    s_valid = 1'b1;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_tick", tick, 0);
    chk("async_rst_ready", s_ready, 0);
    chk("async_rst_underrun", underrun, 0);
    chk("async_rst_pwm", pwm, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_tick(50, n);
    chk("post_rst_first_tick", n, 5);
    chk("post_rst_first_slot", s_ready, 1);
    repeat (20) @(negedge clk);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
